// File: rtl/riscv_mem_pkg.sv
// Shared memory-interface types: access size encoding and datapath width,
// common to the core memory, the LSU and the arbiter.
package riscv_mem_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    MEM_NONE = 2'd0,
    MEM_BYTE = 2'd1,
    MEM_HALF = 2'd2,
    MEM_WORD = 2'd3
  } mem_size_e;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one registered-read, sized-write memory between fetch and the LSU.
// Data reads beat fetch reads unless fetch has lost STARVE_LIMIT times in a row.
module mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req_valid,
  output logic            if_req_ready,
  input  logic [XLEN-1:0] if_req_addr,
  output logic            if_rsp_valid,
  output logic [XLEN-1:0] if_rsp_data,
  input  logic            d_req_valid,
  output logic            d_req_ready,
  input  logic            d_req_we,
  input  logic [1:0]      d_req_size,
  input  logic [XLEN-1:0] d_req_addr,
  input  logic [XLEN-1:0] d_req_wdata,
  output logic            d_rsp_valid,
  output logic [XLEN-1:0] d_rsp_data,
  output logic [XLEN-1:0] mem_rd_addr,
  input  logic [XLEN-1:0] mem_rd_data,
  output logic [1:0]      mem_wr_en,
  output logic [XLEN-1:0] mem_wr_addr,
  output logic [XLEN-1:0] mem_wr_data
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt, starve_next;
  logic       if_pend, d_pend, d_rd_pend;
  logic       wr_req, rd_req, fetch_pri;
  logic       if_grant, d_rd_grant, d_wr_grant;

  always_comb begin
    wr_req      = d_req_valid && d_req_we;
    rd_req      = d_req_valid && !d_req_we;
    fetch_pri   = (starve_cnt == LIMIT);
    if_grant    = 1'b0;
    d_rd_grant  = 1'b0;
    d_wr_grant  = 1'b0;
    starve_next = starve_cnt;

    if (rst_n) begin
      if_grant   = if_req_valid && (!rd_req || fetch_pri);
      d_rd_grant = rd_req && !if_grant;
      d_wr_grant = wr_req;
    end

    if_req_ready = if_grant;
    d_req_ready  = rst_n && (d_req_we || d_rd_grant);

    // Writes bypass arbitration entirely; the write port is never contended.
    mem_wr_en    = d_wr_grant ? d_req_size : MEM_NONE;
    mem_wr_addr  = d_req_addr;
    mem_wr_data  = d_req_wdata;
    mem_rd_addr  = d_rd_grant ? d_req_addr : if_req_addr;

    if (if_grant) begin
      starve_next = '0;
    end else if (if_req_valid && d_rd_grant && (starve_cnt != LIMIT)) begin
      starve_next = starve_cnt + 4'd1;
    end

    if_rsp_valid = if_pend;
    if_rsp_data  = if_pend ? mem_rd_data : '0;
    d_rsp_valid  = d_pend;
    d_rsp_data   = (d_pend && d_rd_pend) ? mem_rd_data : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      if_pend    <= 1'b0;
      d_pend     <= 1'b0;
      d_rd_pend  <= 1'b0;
    end else begin
      starve_cnt <= starve_next;
      if_pend    <= if_grant;
      d_pend     <= d_rd_grant || d_wr_grant;
      d_rd_pend  <= d_rd_grant;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte memory model behind the arbiter, expected
// responses queued at request time and matched by a per-cycle monitor.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_req_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        d_req_valid;
  logic        d_req_ready;
  logic        d_req_we;
  logic [1:0]  d_req_size;
  logic [31:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic [31:0] mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic [1:0]  mem_wr_en;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t if_q[$];
  exp_t d_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] mem [0:255];

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_size(d_req_size), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered word read of pre-edge contents, sized byte write.
  always @(posedge clk) begin
    logic [7:0] ra;
    logic [7:0] wa;
    int         n;
    ra = {mem_rd_addr[7:2], 2'b00};
    mem_rd_data <= {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]};
    wa = mem_wr_addr[7:0];
    n  = (mem_wr_en == 2'd1) ? 1 : (mem_wr_en == 2'd2) ? 2 : (mem_wr_en == 2'd3) ? 4 : 0;
    for (int i = 0; i < n; i++) begin
      mem[wa + 8'(i)] <= mem_wr_data[8*i +: 8];
    end
  end

  // Response monitor: each cycle, a response is required exactly where one was queued.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #2;
    if (if_q.size() > 0 && if_q[0].cyc == cyc) begin
      e = if_q.pop_front();
      checks++;
      if (if_rsp_valid !== 1'b1 || if_rsp_data !== e.data) begin
        errors++;
        $display("FAIL if_rsp cyc=%0d: got valid=%b data=%h expected valid=1 data=%h",
                 cyc, if_rsp_valid, if_rsp_data, e.data);
      end else begin
        $display("if_rsp cyc=%0d data=%h ok", cyc, if_rsp_data);
      end
    end else if (if_rsp_valid !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL if_rsp_unexpected cyc=%0d: got valid=%b expected valid=0", cyc, if_rsp_valid);
    end
    if (d_q.size() > 0 && d_q[0].cyc == cyc) begin
      e = d_q.pop_front();
      checks++;
      if (d_rsp_valid !== 1'b1 || d_rsp_data !== e.data) begin
        errors++;
        $display("FAIL d_rsp cyc=%0d: got valid=%b data=%h expected valid=1 data=%h",
                 cyc, d_rsp_valid, d_rsp_data, e.data);
      end else begin
        $display("d_rsp cyc=%0d data=%h ok", cyc, d_rsp_data);
      end
    end else if (d_rsp_valid !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL d_rsp_unexpected cyc=%0d: got valid=%b expected valid=0", cyc, d_rsp_valid);
    end
  end

  task automatic load_word(input logic [7:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem[a + 8'(i)] = w[8*i +: 8];
  endtask

  task automatic idle_inputs();
    if_req_valid = 1'b0; if_req_addr = '0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_size = 2'd0;
    d_req_addr = '0; d_req_wdata = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_size = 2'd3;
    d_req_addr = 32'h40; d_req_wdata = 32'h12345678;
    #1;
    checks++;
    if ({if_req_ready, d_req_ready, mem_wr_en} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready: got if_ready=%b d_ready=%b wr_en=%0d expected 0 0 0",
               if_req_ready, d_req_ready, mem_wr_en);
    end
    checks++;
    if ({if_rsp_valid, d_rsp_valid} !== 2'b00 || if_rsp_data !== 32'h0 || d_rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_rsp: got if=%b/%h d=%b/%h expected 0/0 0/0",
               if_rsp_valid, if_rsp_data, d_rsp_valid, d_rsp_data);
    end
    $display("reset check done");
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_lone_fetch();
    @(negedge clk);
    idle_inputs();
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    #1;
    checks++;
    if (if_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL lone_fetch_ready: got %b expected 1", if_req_ready);
    end
    if_q.push_back('{cyc + 1, 32'hDEADBEEF});
    $display("lone fetch 0x10 issued");
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_byte_write_read();
    @(negedge clk);
    idle_inputs();
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_size = 2'd1;
    d_req_addr = 32'h21; d_req_wdata = 32'h000000AB;
    #1;
    checks++;
    if (d_req_ready !== 1'b1 || mem_wr_en !== 2'd1 || mem_wr_addr !== 32'h21 || mem_wr_data !== 32'hAB) begin
      errors++;
      $display("FAIL byte_write_port: got ready=%b en=%0d addr=%h data=%h expected 1 1 00000021 000000ab",
               d_req_ready, mem_wr_en, mem_wr_addr, mem_wr_data);
    end
    d_q.push_back('{cyc + 1, 32'h0});
    $display("byte write 0x21=ab issued");
    @(negedge clk);
    idle_inputs();
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h20;
    #1;
    checks++;
    if (d_req_ready !== 1'b1 || mem_wr_en !== 2'd0) begin
      errors++;
      $display("FAIL byte_read_ready: got ready=%b en=%0d expected 1 0", d_req_ready, mem_wr_en);
    end
    d_q.push_back('{cyc + 1, 32'h4433AB11});
    $display("data read 0x20 issued");
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_write_fetch();
    @(negedge clk);
    idle_inputs();
    if_req_valid = 1'b1; if_req_addr = 32'h30;
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_size = 2'd3;
    d_req_addr = 32'h40; d_req_wdata = 32'hCAFEF00D;
    #1;
    checks++;
    if (if_req_ready !== 1'b1 || d_req_ready !== 1'b1 || mem_wr_en !== 2'd3) begin
      errors++;
      $display("FAIL write_fetch_grant: got if_ready=%b d_ready=%b en=%0d expected 1 1 3",
               if_req_ready, d_req_ready, mem_wr_en);
    end
    if_q.push_back('{cyc + 1, 32'h11112222});
    d_q.push_back('{cyc + 1, 32'h0});
    $display("write 0x40 + fetch 0x30 issued");
    @(negedge clk);
    idle_inputs();
    if_req_valid = 1'b1; if_req_addr = 32'h40;
    if_q.push_back('{cyc + 1, 32'hCAFEF00D});
    $display("fetch 0x40 issued");
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_illegal_size();
    @(negedge clk);
    idle_inputs();
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_size = 2'd0;
    d_req_addr = 32'h50; d_req_wdata = 32'hFFFFFFFF;
    #1;
    checks++;
    if (d_req_ready !== 1'b1 || mem_wr_en !== 2'd0) begin
      errors++;
      $display("FAIL size0_write: got ready=%b en=%0d expected 1 0", d_req_ready, mem_wr_en);
    end
    d_q.push_back('{cyc + 1, 32'h0});
    $display("size-0 write 0x50 issued");
    @(negedge clk);
    idle_inputs();
    d_req_valid = 1'b1; d_req_addr = 32'h50;
    d_q.push_back('{cyc + 1, 32'h55667788});
    $display("data read 0x50 issued");
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_starvation();
    for (int k = 0; k < 15; k++) begin
      logic fetch_turn;
      @(negedge clk);
      if_req_valid = 1'b1; if_req_addr = 32'h10;
      d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h20;
      fetch_turn = (k % 5) == 4;
      #1;
      checks++;
      if (if_req_ready !== fetch_turn || d_req_ready !== !fetch_turn) begin
        errors++;
        $display("FAIL starve_grant k=%0d: got if_ready=%b d_ready=%b expected %b %b",
                 k, if_req_ready, d_req_ready, fetch_turn, !fetch_turn);
      end else begin
        $display("starve k=%0d fetch_grant=%b", k, fetch_turn);
      end
      if (fetch_turn) if_q.push_back('{cyc + 1, 32'hDEADBEEF});
      else            d_q.push_back('{cyc + 1, 32'h4433AB11});
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    idle_inputs();
    d_req_valid = 1'b1; d_req_addr = 32'h20;
    #1;
    checks++;
    if (d_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_grant: got %b expected 1", d_req_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (d_rsp_valid !== 1'b0 || if_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_drop: got d=%b if=%b expected 0 0", d_rsp_valid, if_rsp_valid);
    end
    $display("reset asserted after read grant");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    if_q.push_back('{cyc + 1, 32'hDEADBEEF});
    $display("fetch 0x10 after reset issued");
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    load_word(8'h10, 32'hDEADBEEF);
    load_word(8'h20, 32'h44332211);
    load_word(8'h30, 32'h11112222);
    load_word(8'h50, 32'h55667788);

    test_reset();
    test_lone_fetch();
    test_byte_write_read();
    test_write_fetch();
    test_illegal_size();
    test_starvation();
    test_reset_mid();

    for (int t = 0; t < 10 && (if_q.size() > 0 || d_q.size() > 0); t++) @(negedge clk);
    checks++;
    if (if_q.size() != 0 || d_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got pending if=%0d d=%0d expected 0 0", if_q.size(), d_q.size());
    end
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares the single byte-addressable core memory (one word read port, one sized write port, registered 1-cycle read) between instruction fetch and the load/store unit.
- Each requester gets a valid/ready request channel and a fixed-latency response channel.
- Arbitration is data-over-fetch, with a bounded starvation guarantee for fetch.
- Sits between the core pipeline and the memory instance.

## Interface
Parameters:
- STARVE_LIMIT, 4, consecutive fetch losses after which fetch is granted over a data read (1..15).

Ports (clock is `clk`; reset is `rst_n`, asynchronous, active-low):
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- if_req_valid  in  1  fetch read request
- if_req_ready  out  1  fetch request accepted this cycle
- if_req_addr  in  32  fetch byte address
- if_rsp_valid  out  1  fetch read data valid
- if_rsp_data  out  32  fetch read data, raw little-endian word
- d_req_valid  in  1  data request
- d_req_ready  out  1  data request accepted this cycle
- d_req_we  in  1  1 = write, 0 = read
- d_req_size  in  2  write size: 1 = byte, 2 = half, 3 = word, 0 = none
- d_req_addr  in  32  data byte address
- d_req_wdata  in  32  write data, LSB-aligned
- d_rsp_valid  out  1  data response: read data or write acknowledge
- d_rsp_data  out  32  read word; 0 for write acknowledges
- mem_rd_addr  out  32  memory read address
- mem_rd_data  in  32  memory read data, valid 1 cycle after address
- mem_wr_en  out  2  memory write size, same encoding as d_req_size
- mem_wr_addr  out  32  memory write address
- mem_wr_data  out  32  memory write data

## Operation
- **Handshake.** A request transfers when valid && ready in the same cycle. Requesters must not make valid depend on ready. Ready is combinational from both valids and the starvation count.
- **Data write.** The write port is never contended.
  - d_req_ready = 1 whenever d_req_we = 1.
  - The write drives mem_wr_en = d_req_size, mem_wr_addr and mem_wr_data directly.
  - A write with d_req_size = 0 is accepted, writes nothing, and is still acknowledged.
- **Read port contention.**
  - A data read and a fetch read in the same cycle contend.
  - Data wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
  - A lone request of either kind is always granted.
- **Concurrent write and fetch.** A data write plus a fetch read are both granted in the same cycle.
- **starve_cnt** (4-bit):
  - Increments, saturating at STARVE_LIMIT, in each cycle where fetch is valid and loses to a data read.
  - Clears in each cycle fetch is granted.
  - Otherwise holds.
- **mem_rd_addr** is the granted read address, or if_req_addr when no read is granted (don't-care read).
- **Response routing.**
  - Registered flags if_pend and d_pend record which port owned the grant.
  - Responses are produced in order; no response backpressure exists.
  - d_rsp_data = mem_rd_data for reads and 0 for write acks.
- **Alignment.** No alignment checking. Sub-word extraction and sign extension are the core's job.

## Timing
- Request accepted at edge t → response valid during cycle t+1, for one cycle. Throughput is one read plus one write per cycle.
- Write accepted at edge t lands at edge t; a read accepted at t+1 returns the new data.
- **Same-cycle overlap.** If a fetch read and a data write overlap bytes in the same cycle, fetch returns the pre-write contents. This is accepted behaviour.
- **Reset values.**
  - if_rsp_valid = 0, d_rsp_valid = 0, response data = 0.
  - starve_cnt = 0, if_pend = d_pend = 0.
  - mem_wr_en is forced to 0 while rst_n = 0; both ready outputs are 0 while rst_n = 0.
- **Reset mid-operation.** The pending response is dropped. No rsp_valid appears after reset deasserts until a new grant is made.
- **Saturation.** At STARVE_LIMIT, the next contended cycle grants fetch; the data read stalls exactly one cycle.

## Structure
- Package `riscv_mem_pkg`:
  - Enum mem_size_e (MEM_NONE = 0, MEM_BYTE = 1, MEM_HALF = 2, MEM_WORD = 3), shared with the memory and the LSU.
  - Localparam XLEN = 32.
- No sub-module. The arbiter, starvation counter and response flags are a single always_ff plus an always_comb.

## Test plan
- **Lone fetch:** fetch read 0x10 over a word 0xDEADBEEF → if_req_ready = 1 same cycle; if_rsp_data = 0xDEADBEEF next cycle; d_rsp_valid = 0.
- **Byte write then read:** data write size 1, addr 0x21, data 0xAB; then data read 0x20 the following cycle → ack with d_rsp_data = 0; then read returns byte1 = 0xAB, other bytes unchanged.
- **Write plus fetch:** data write and fetch read in the same cycle → both ready = 1; mem_wr_en = 3; fetch response next cycle.
- **Starvation:** continuous data reads plus continuous fetch, STARVE_LIMIT = 4 → fetch granted on the 5th contended cycle; starve_cnt returns to 0; pattern repeats every 5 cycles.
- **Illegal size:** data write with size 0 → mem_wr_en = 0, memory unchanged, ack still issued.
- **Reset mid-operation:** rst_n asserted in the cycle after a read grant → no rsp_valid appears; after release, the first grant responds normally.
